// File: rtl/counter_reload_ctrl_if.sv
// Bundle between the reload controller and its upstream/downstream peers:
// configuration handshake, run request, counter feedback and counter drive.
interface counter_reload_ctrl_if #(
    parameter int WIDTH = 8
);
    // Handshake: a config word transfers on a clock edge where cfg_valid && cfg_ready.
    // The offerer holds cfg_start/cfg_end/cfg_oneshot stable while cfg_valid is high;
    // cfg_ready never depends on cfg_valid, so the offerer may wait on it freely.
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_end;
    logic             cfg_oneshot;

    logic             enable;
    logic [WIDTH-1:0] count;

    logic             load;
    logic [WIDTH-1:0] data;
    logic             tick;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_start, cfg_end, cfg_oneshot, enable, count,
        input  cfg_ready, load, data, tick, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_end, cfg_oneshot, enable, count,
        output cfg_ready, load, data, tick, busy, done
    );
endinterface

// File: rtl/counter_reload_ctrl.sv
// Turns an external 8-bit up counter with load into a programmable period timer:
// runs start..end inclusive (wrapping), reloads start, periodic or one-shot.
module counter_reload_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_reload_ctrl_if.slave bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             oneshot_q, oneshot_d;

    logic             cfg_ready;
    logic             cfg_fire;
    logic             match;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             tick;
    logic             busy;
    logic             done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            end_q     <= '1;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            oneshot_q <= oneshot_d;
        end
    end

    // Ready depends only on state and reset, so it is safe to decode before the FSM.
    always_comb begin
        cfg_ready = rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    assign cfg_fire = bus.cfg_valid && cfg_ready;
    assign match    = (bus.count == end_q);

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        end_d     = end_q;
        oneshot_d = oneshot_q;
        load      = 1'b1;
        data      = start_q;
        tick      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        // cfg_fire is only possible in IDLE/DONE, so RUN never sees its config move.
        if (cfg_fire) begin
            start_d   = bus.cfg_start;
            end_d     = bus.cfg_end;
            oneshot_d = bus.cfg_oneshot;
        end

        case (state_q)
            ST_IDLE: begin
                if (!cfg_fire && bus.enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (match) begin
                    tick = rst;
                    if (oneshot_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    load = 1'b0;
                end
            end
            ST_DONE: begin
                data = end_q;
                done = 1'b1;
                if (cfg_fire || !bus.enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.load      = load;
    assign bus.data      = data;
    assign bus.tick      = tick;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign dbg_state     = state_q;

endmodule
